// File: rtl/triangle_pkg.sv
// Shared types for the triangle generator and its run sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package triangle_pkg;

  // Default width of the generator output.
  localparam int N_DEFAULT = 8;

  // Sequencer run states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  // Generator ramp direction.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } tri_dir_t;

endpackage

// File: rtl/strobe_divider.sv
// Prescaler: emits a one-cycle tick every P clocks, P = max(period, 1).
// Latency: tick is combinational from the counter; first tick P-1 cycles after clr drops.
// Backpressure: none; clr holds the counter at zero.
// Ports: clk, rst (sync, active-high), clr (hold at 0), period, tick.
module strobe_divider #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [PRE_W-1:0] period,
  output logic             tick
);

  logic [PRE_W-1:0] r_cnt;
  logic [PRE_W-1:0] w_last;

  // A period of zero behaves as one: tick on every cycle.
  assign w_last = (period == '0) ? '0 : period - {{(PRE_W-1){1'b0}}, 1'b1};
  assign tick   = (r_cnt == w_last);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(PRE_W-1){1'b1}} & '0, 1'b1};
    end
  end

endmodule

// File: rtl/triangle_generator.sv
// Triangle wave generator: counts 0 -> 2^N-1 -> 0 one step per ena.
// Latency: out updates one cycle after an ena; rst clears out to 0, direction up.
// Backpressure: none; ena low simply holds the current value.
// Ports: clk, rst (sync, active-high), ena (step strobe), out (wave value).
module triangle_generator
  import triangle_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  output logic [N-1:0] out
);

  localparam logic [N-1:0] TOP_M1 = {{(N-1){1'b1}}, 1'b0};
  localparam logic [N-1:0] ONE    = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] r_out;
  tri_dir_t     r_dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_dir <= DIR_UP;
    end else if (ena) begin
      if (r_dir == DIR_UP) begin
        r_out <= r_out + ONE;
        // Turn around as the peak value is reached.
        if (r_out == TOP_M1) r_dir <= DIR_DOWN;
      end else begin
        r_out <= r_out - ONE;
        if (r_out == ONE) r_dir <= DIR_UP;
      end
    end
  end

  assign out = r_out;

endmodule

// File: rtl/triangle_sequencer.sv
// Run controller for triangle_generator: resets it, paces it via ena, counts
// periods and stops at a zero crossing (burst end or stop request).
// Latency: gen_ena/gen_rst/busy decoded from state; done registered, one cycle after run end.
// Ports: clk, rst, start, stop, period, burst, wave (generator out) ->
//        gen_rst, gen_ena, busy, done, periods_done.
module triangle_sequencer
  import triangle_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int PRE_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PRE_W-1:0] period,
  input  logic [CNT_W-1:0] burst,
  input  logic [N-1:0]     wave,
  output logic             gen_rst,
  output logic             gen_ena,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] periods_done
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [PRE_W-1:0] r_period;
  logic [CNT_W-1:0] r_burst;
  logic [CNT_W-1:0] r_periods;
  logic [N-1:0]     r_wave_prev;
  logic             r_done;

  logic             w_tick;
  logic             w_active;
  logic             w_complete;
  logic [CNT_W:0]   w_pd_inc;
  logic             w_last_burst;
  logic             w_finishing;
  logic             w_stop_zero;
  logic             w_end_run;

  // Prescaler is held at zero outside RUN/DRAIN, so RUN always starts cleared.
  strobe_divider #(
    .PRE_W (PRE_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (!w_active),
    .period (r_period),
    .tick   (w_tick)
  );

  assign w_active     = (r_state == RUN) || (r_state == DRAIN);
  // A period ends when the wave falls back onto zero.
  assign w_complete   = w_active && (wave == '0) && (r_wave_prev != '0);
  assign w_pd_inc     = {1'b0, r_periods} + {{CNT_W{1'b0}}, 1'b1};
  assign w_last_burst = (r_burst != '0) && (w_pd_inc == {1'b0, r_burst});
  assign w_finishing  = w_complete &&
                        (((r_state == RUN) && w_last_burst) || (r_state == DRAIN));
  // Stop while already at zero: the generator is at its start point, exit now.
  assign w_stop_zero  = (r_state == RUN) && stop && (wave == '0);
  // Any run-ending cycle suppresses ena so the wave rests at zero.
  assign w_end_run    = w_finishing || w_stop_zero;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    gen_ena = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = ARM;
      end
      ARM: begin
        w_next = RUN;
      end
      RUN: begin
        gen_ena = w_tick && !w_end_run;
        if (w_end_run)  w_next = IDLE;
        else if (stop)  w_next = DRAIN;
      end
      DRAIN: begin
        gen_ena = w_tick && !w_end_run;
        if (w_finishing) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period    <= '0;
      r_burst     <= '0;
      r_periods   <= '0;
      r_wave_prev <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= w_end_run;
      r_wave_prev <= (r_state == ARM) ? '0 : wave;
      if ((r_state == IDLE) && start) begin
        r_period  <= period;
        r_burst   <= burst;
        r_periods <= '0;
      end else if (w_complete && (r_periods != '1)) begin
        r_periods <= w_pd_inc[CNT_W-1:0];
      end
    end
  end

  assign gen_rst      = rst || (r_state == ARM);
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign periods_done = r_periods;

endmodule

// File: tb/tb_triangle_sequencer.sv
module tb_triangle_sequencer;

  localparam int N     = 4;
  localparam int PRE_W = 16;
  localparam int CNT_W = 8;
  localparam int TOP   = (1 << N) - 1;
  localparam int FULL  = 2 * TOP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst    = 1'b1;
  logic             start  = 1'b0;
  logic             stop   = 1'b0;
  logic [PRE_W-1:0] period = '0;
  logic [CNT_W-1:0] burst  = '0;
  logic [N-1:0]     wave;
  logic             gen_rst, gen_ena, busy, done;
  logic [CNT_W-1:0] periods_done;

  triangle_sequencer #(.N(N), .PRE_W(PRE_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .period       (period),
    .burst        (burst),
    .wave         (wave),
    .gen_rst      (gen_rst),
    .gen_ena      (gen_ena),
    .busy         (busy),
    .done         (done),
    .periods_done (periods_done)
  );

  triangle_generator #(.N(N)) u_gen (
    .clk (clk),
    .rst (gen_rst),
    .ena (gen_ena),
    .out (wave)
  );

  int now    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: phase 0 idle, 1 arm, 2 run, 3 drain; the generator is
  // represented only by its step count, its value derived arithmetically.
  int m_phase = 0, m_P = 1, m_burst = 0, m_pd = 0, m_steps = 0, m_cyc = 0;
  bit m_fresh = 1'b0, m_done = 1'b0;

  // Values sampled on the last stepped cycle.
  int s_wave, s_ena, s_done, s_busy, s_rst, s_pd;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", tag, got, exp, now);
  endtask

  function automatic int tri_val(input int s);
    int v;
    v = s % FULL;
    return (v <= TOP) ? v : FULL - v;
  endfunction

  // One clock cycle: compare DUT against model mid-cycle, then advance both.
  task automatic step();
    bit active, compl, fin, szero, end_run, ena_e;
    int wexp;
    @(negedge clk);
    active  = (m_phase >= 2);
    wexp    = tri_val(m_steps);
    compl   = active && m_fresh && (m_steps > 0) && (m_steps % FULL == 0);
    fin     = compl && (((m_phase == 2) && (m_burst != 0) && (m_pd + 1 == m_burst)) ||
                        (m_phase == 3));
    szero   = (m_phase == 2) && stop && (wexp == 0);
    end_run = fin || szero;
    ena_e   = active && (m_cyc % m_P == m_P - 1) && !end_run;

    s_wave = int'(wave);  s_ena = int'(gen_ena); s_done = int'(done);
    s_busy = int'(busy);  s_rst = int'(gen_rst); s_pd   = int'(periods_done);
    check("wave",         s_wave, wexp);
    check("gen_ena",      s_ena,  int'(ena_e));
    check("busy",         s_busy, int'(m_phase != 0));
    check("gen_rst",      s_rst,  int'(rst || (m_phase == 1)));
    check("done",         s_done, int'(m_done));
    check("periods_done", s_pd,   m_pd);

    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_steps = 0; m_pd = 0; m_done = 1'b0; m_fresh = 1'b0; m_cyc = 0;
    end else begin
      m_done  = end_run;
      m_fresh = 1'b0;
      case (m_phase)
        0: if (start) begin
             m_P     = (period == '0) ? 1 : int'(period);
             m_burst = int'(burst);
             m_pd    = 0;
             m_phase = 1;
           end
        1: begin m_phase = 2; m_cyc = 0; m_steps = 0; end
        default: begin
          if (ena_e) begin m_steps++; m_fresh = 1'b1; end
          m_cyc++;
          if (compl && m_pd < 255) m_pd++;
          if (end_run) m_phase = 0;
          else if (m_phase == 2 && stop) m_phase = 3;
        end
      endcase
    end
    #1;
    now++;
  endtask

  task automatic go_to(input int c);
    while (now <= c) step();
  endtask

  task automatic wait_wave(input int val, input string tag);
    int k = 0;
    while (int'(wave) != val && k < 400) begin step(); k++; end
    if (k >= 400) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    s_done = 0;
    while (s_done == 0 && k < 400) begin step(); k++; end
    if (k >= 400) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic kick(input int p, input int b);
    period = PRE_W'(p);
    burst  = CNT_W'(b);
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    int t, last, npulse, seen, wmax, nd, k;

    // Reset state
    rst = 1'b1;
    step(); step();
    check("rst_busy", s_busy, 0);
    check("rst_genrst", s_rst, 1);
    check("rst_done", s_done, 0);
    check("rst_wave", s_wave, 0);
    rst = 1'b0;
    step();

    // Burst of two, period 1
    t = now;
    kick(1, 2);
    go_to(t + 1);  check("b2_genrst_arm", s_rst, 1);
    go_to(t + 17); check("b2_peak", s_wave, 15);
    go_to(t + 32); check("b2_zero1", s_wave, 0);
    go_to(t + 33); check("b2_pd1", s_pd, 1);
    go_to(t + 62); check("b2_zero2", s_wave, 0); check("b2_ena_low", s_ena, 0);
    go_to(t + 63); check("b2_done", s_done, 1); check("b2_busy", s_busy, 0);
    check("b2_pd2", s_pd, 2);
    go_to(t + 70); check("b2_rest", s_wave, 0);

    // Prescaled single burst, period 3
    t = now; last = 0; npulse = 0; seen = 0;
    kick(3, 1);
    while (now < t + 400) begin
      step();
      if (s_ena != 0) begin
        if (npulse == 0) check("p3_first_ena", now - 1, t + 4);
        else             check("p3_ena_gap", now - 1 - last, 3);
        last = now - 1;
        npulse++;
      end
      if (s_done != 0) begin seen = 1; break; end
    end
    check("p3_pulses", npulse, 30);
    check("p3_done_seen", seen, 1);
    check("p3_done_time", now - 1, t + 93);
    check("p3_pd", s_pd, 1);

    // Continuous run, period 0, stop at 9 rising -> drain
    kick(0, 0);
    wait_wave(9, "dr_nine");
    stop = 1'b1; step(); stop = 1'b0;
    check("dr_busy_after_stop", s_busy, 1);
    wmax = 9; seen = 0; k = 0;
    while (k < 400) begin
      step(); k++;
      if (s_wave > wmax) wmax = s_wave;
      if (s_done != 0) begin seen = 1; break; end
    end
    check("dr_max", wmax, 15);
    check("dr_done_seen", seen, 1);
    check("dr_wave_zero", s_wave, 0);
    check("dr_pd", s_pd, 1);
    nd = 0;
    repeat (5) begin step(); nd += s_ena; end
    check("dr_no_ena_after", nd, 0);

    // Stop exactly at a zero crossing
    kick(1, 0);
    wait_wave(15, "sz_peak");
    wait_wave(0, "sz_zero");
    stop = 1'b1; step(); stop = 1'b0;
    check("sz_busy", s_busy, 1);
    step();
    check("sz_done", s_done, 1);
    check("sz_idle", s_busy, 0);
    check("sz_pd", s_pd, 1);

    // Start during RUN ignored; stop on final completion gives one done
    kick(2, 1);
    wait_wave(5, "fb_five");
    start = 1'b1; step(); start = 1'b0;
    step();
    check("fb_no_rearm", s_rst, 0);
    check("fb_pd_kept", s_pd, 0);
    wait_wave(15, "fb_peak");
    wait_wave(0, "fb_zero");
    stop = 1'b1; step(); stop = 1'b0;
    nd = 0;
    repeat (10) begin step(); nd += s_done; end
    check("fb_one_done", nd, 1);
    check("fb_pd", s_pd, 1);

    // Reset mid-run during DRAIN at wave 6
    kick(1, 0);
    wait_wave(9, "mr_nine");
    stop = 1'b1; step(); stop = 1'b0;
    wait_wave(15, "mr_peak");
    wait_wave(6, "mr_six");
    rst = 1'b1; step(); rst = 1'b0;
    check("mr_genrst", s_rst, 1);
    step();
    check("mr_busy", s_busy, 0);
    check("mr_wave", s_wave, 0);
    check("mr_pd", s_pd, 0);
    check("mr_done", s_done, 0);
    kick(1, 1);
    wait_done("mr_rerun");
    check("mr_rerun_pd", s_pd, 1);

    // Randomized traffic against the model
    repeat (3000) begin
      rst    = ($urandom_range(0, 499) == 0);
      start  = ($urandom_range(0, 19) == 0);
      stop   = ($urandom_range(0, 59) == 0);
      period = PRE_W'($urandom_range(0, 3));
      burst  = CNT_W'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
